// File: rtl/sha3_bridge_pkg.sv
// Shared command bytes, FSM state encoding and the nibble-to-ASCII helper
// used by the SHA3 stream bridge.
package sha3_bridge_pkg;

  localparam logic [7:0] CMD_BIN = 8'h01;
  localparam logic [7:0] CMD_HEX = 8'h02;
  localparam logic [7:0] NAK     = 8'h15;
  localparam logic [7:0] NL      = 8'h0A;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_PUSH,
    S_WAIT_DIG,
    S_TX_BYTE,
    S_TX_HI,
    S_TX_LO,
    S_TX_NL,
    S_NAK
  } state_t;

  // Lowercase hex digit for one nibble.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] i_nib);
    if (i_nib < 4'd10) return 8'h30 + {4'h0, i_nib};
    else               return 8'h57 + {4'h0, i_nib};
  endfunction

endpackage

// File: rtl/sha3_byte_packer.sv
// Packs bytes into a WORD_W-bit beat, first byte in bits [7:0]; tracks the fill
// count. Clear has priority over shift; unfilled lanes are always zero.
module sha3_byte_packer #(
  parameter int WORD_W = 32,
  localparam int NB = WORD_W / 8,
  localparam int KW = $clog2(NB) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_shift,
  input  logic [7:0]        i_byte,
  output logic [WORD_W-1:0] o_data,
  output logic [KW-1:0]     o_fill
);

  logic [WORD_W-1:0] r_data;
  logic [KW-1:0]     r_fill;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_fill <= '0;
    end else if (i_clr) begin
      r_data <= '0;
      r_fill <= '0;
    end else if (i_shift) begin
      r_data[{r_fill[KW-2:0], 3'b000} +: 8] <= i_byte;
      r_fill <= r_fill + 1'b1;
    end
  end

  assign o_data = r_data;
  assign o_fill = r_fill;

endmodule

// File: rtl/sha3_stream_bridge.sv
// UART byte stream <-> SHA3 core bridge: parses CMD/LEN/payload frames into beats,
// returns the digest as raw binary or lowercase hex, NAKs bad commands and timeouts.
module sha3_stream_bridge
  import sha3_bridge_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int LEN_BYTES   = 2,
  parameter int DIGEST_BITS = 256,
  parameter int TIMEOUT_CYC = 1_250_000,
  localparam int NB  = WORD_W / 8,
  localparam int KW  = $clog2(NB) + 1,
  localparam int NW  = DIGEST_BITS / WORD_W,
  localparam int CW  = 8 * LEN_BYTES,
  localparam int WCW = $clog2(NW) + 1,
  localparam int LIW = $clog2(LEN_BYTES) + 1,
  localparam int TW  = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  output logic              rx_ack,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [WORD_W-1:0] sha3_in_data,
  output logic              sha3_in_valid,
  output logic              sha3_in_last,
  output logic [KW-1:0]     sha3_in_keep,
  input  logic              sha3_in_ready,
  output logic              sha3_abort,
  input  logic [WORD_W-1:0] sha3_out_data,
  input  logic              sha3_out_valid,
  output logic              sha3_out_ready,
  output logic              busy
);

  state_t            r_state;
  logic              r_hex;
  logic [CW-1:0]     r_len_cnt;
  logic [LIW-1:0]    r_len_idx;
  logic [TW-1:0]     r_timer;
  logic              r_pushed;
  logic              r_in_valid;
  logic              r_in_last;
  logic [KW-1:0]     r_in_keep;
  logic              r_abort;
  logic [WORD_W-1:0] r_dig;
  logic [KW-1:0]     r_byte_idx;
  logic [WCW-1:0]    r_word_cnt;
  logic              r_tx_valid;
  logic [7:0]        r_tx_data;

  logic              w_rx_phase;
  logic              w_consume;
  logic              w_expire;
  logic [CW-1:0]     w_len_next;
  logic [KW-1:0]     w_fill;
  logic [KW-1:0]     w_fill_inc;
  logic [WORD_W-1:0] w_dig_nxt;
  logic              w_pk_clr;
  logic              w_pk_shift;

  assign w_rx_phase = (r_state == S_LEN) || (r_state == S_PAYLOAD);
  // Acking is combinational so the byte is taken on the same edge it is acked.
  assign w_consume  = rx_ready && ((r_state == S_IDLE) || w_rx_phase);
  assign w_expire   = w_rx_phase && !w_consume && (r_timer == TW'(TIMEOUT_CYC - 1));
  assign w_len_next = (r_len_cnt << 8) | CW'(rx_data);
  assign w_fill_inc = w_fill + 1'b1;
  assign w_dig_nxt  = r_dig >> 8;
  assign w_pk_shift = w_consume && (r_state == S_PAYLOAD);
  assign w_pk_clr   = (r_state == S_IDLE) || w_expire
                    || ((r_state == S_PUSH) && sha3_in_ready);

  sha3_byte_packer #(.WORD_W(WORD_W)) u_packer (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_pk_clr),
    .i_shift (w_pk_shift),
    .i_byte  (rx_data),
    .o_data  (sha3_in_data),
    .o_fill  (w_fill)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_hex      <= 1'b0;
      r_len_cnt  <= '0;
      r_len_idx  <= '0;
      r_timer    <= '0;
      r_pushed   <= 1'b0;
      r_in_valid <= 1'b0;
      r_in_last  <= 1'b0;
      r_in_keep  <= '0;
      r_abort    <= 1'b0;
      r_dig      <= '0;
      r_byte_idx <= '0;
      r_word_cnt <= '0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_abort <= 1'b0;
      if (w_rx_phase && !w_consume) r_timer <= r_timer + 1'b1;
      else                          r_timer <= '0;

      case (r_state)
        S_IDLE: if (w_consume) begin
          r_pushed  <= 1'b0;
          r_len_idx <= '0;
          r_len_cnt <= '0;
          if (rx_data == CMD_BIN || rx_data == CMD_HEX) begin
            r_hex   <= (rx_data == CMD_HEX);
            r_state <= S_LEN;
          end else begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= NAK;
            r_state    <= S_NAK;
          end
        end

        S_LEN, S_PAYLOAD: if (w_consume) begin
          if (r_state == S_LEN) begin
            r_len_cnt <= w_len_next;
            r_len_idx <= r_len_idx + 1'b1;
            if (r_len_idx == LIW'(LEN_BYTES - 1)) begin
              if (w_len_next == '0) begin
                r_in_valid <= 1'b1;
                r_in_last  <= 1'b1;
                r_in_keep  <= '0;
                r_state    <= S_PUSH;
              end else begin
                r_state <= S_PAYLOAD;
              end
            end
          end else begin
            r_len_cnt <= r_len_cnt - 1'b1;
            if (r_len_cnt == CW'(1) || w_fill_inc == KW'(NB)) begin
              r_in_valid <= 1'b1;
              r_in_last  <= (r_len_cnt == CW'(1));
              r_in_keep  <= w_fill_inc;
              r_state    <= S_PUSH;
            end
          end
        end else if (w_expire) begin
          // The core only needs discarding if it has already seen part of the message.
          r_abort    <= r_pushed;
          r_tx_valid <= 1'b1;
          r_tx_data  <= NAK;
          r_state    <= S_NAK;
        end

        S_PUSH: if (sha3_in_ready) begin
          r_in_valid <= 1'b0;
          r_in_last  <= 1'b0;
          r_in_keep  <= '0;
          r_pushed   <= 1'b1;
          r_word_cnt <= '0;
          r_state    <= r_in_last ? S_WAIT_DIG : S_PAYLOAD;
        end

        S_WAIT_DIG: if (sha3_out_valid) begin
          r_dig      <= sha3_out_data;
          r_byte_idx <= '0;
          r_tx_valid <= 1'b1;
          if (r_hex) begin
            r_tx_data <= nibble_to_ascii(sha3_out_data[7:4]);
            r_state   <= S_TX_HI;
          end else begin
            r_tx_data <= sha3_out_data[7:0];
            r_state   <= S_TX_BYTE;
          end
        end

        S_TX_HI: if (tx_ready) begin
          r_tx_data <= nibble_to_ascii(r_dig[3:0]);
          r_state   <= S_TX_LO;
        end

        S_TX_BYTE, S_TX_LO: if (tx_ready) begin
          if (r_byte_idx == KW'(NB - 1)) begin
            r_word_cnt <= r_word_cnt + 1'b1;
            if (r_word_cnt == WCW'(NW - 1) && r_hex) begin
              r_tx_data <= NL;
              r_state   <= S_TX_NL;
            end else begin
              r_tx_valid <= 1'b0;
              r_tx_data  <= '0;
              r_state    <= (r_word_cnt == WCW'(NW - 1)) ? S_IDLE : S_WAIT_DIG;
            end
          end else begin
            r_byte_idx <= r_byte_idx + 1'b1;
            r_dig      <= w_dig_nxt;
            r_tx_data  <= r_hex ? nibble_to_ascii(w_dig_nxt[7:4]) : w_dig_nxt[7:0];
            r_state    <= r_hex ? S_TX_HI : S_TX_BYTE;
          end
        end

        S_TX_NL, S_NAK: if (tx_ready) begin
          r_tx_valid <= 1'b0;
          r_tx_data  <= '0;
          r_state    <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rx_ack         = w_consume;
  assign tx_data        = r_tx_data;
  assign tx_valid       = r_tx_valid;
  assign sha3_in_valid  = r_in_valid;
  assign sha3_in_last   = r_in_last;
  assign sha3_in_keep   = r_in_keep;
  assign sha3_abort     = r_abort;
  assign sha3_out_ready = (r_state == S_WAIT_DIG);
  assign busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_sha3_stream_bridge.sv
// Directed bench for sha3_stream_bridge: UART RX driver, SHA3 sink/digest stub, TX sink.
module tb_sha3_stream_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready = 1'b0;
  logic        rx_ack;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [31:0] sha3_in_data;
  logic        sha3_in_valid;
  logic        sha3_in_last;
  logic [2:0]  sha3_in_keep;
  logic        sha3_in_ready = 1'b1;
  logic        sha3_abort;
  logic [31:0] sha3_out_data = 32'h0;
  logic        sha3_out_valid = 1'b0;
  logic        sha3_out_ready;
  logic        busy;

  always #5 clk = ~clk;

  sha3_stream_bridge #(
    .WORD_W(32), .LEN_BYTES(2), .DIGEST_BITS(256), .TIMEOUT_CYC(100)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_ready(rx_ready), .rx_ack(rx_ack),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .sha3_in_data(sha3_in_data), .sha3_in_valid(sha3_in_valid),
    .sha3_in_last(sha3_in_last), .sha3_in_keep(sha3_in_keep),
    .sha3_in_ready(sha3_in_ready), .sha3_abort(sha3_abort),
    .sha3_out_data(sha3_out_data), .sha3_out_valid(sha3_out_valid),
    .sha3_out_ready(sha3_out_ready), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard state fed by the monitors.
  logic [31:0] q_dat[$];
  logic [2:0]  q_keep[$];
  logic        q_last[$];
  logic [7:0]  q_tx[$];
  int          n_ack = 0;
  int          n_abort = 0;
  int          n_ack_in_push = 0;
  logic        dig_pending = 1'b0;
  int          dig_idx = 0;
  logic        dig_xfer = 1'b0;
  logic        tx_throttle = 1'b0;
  int          cyc = 0;
  logic        in_stalled = 1'b0;
  logic [36:0] in_hold = '0;
  logic        tx_stalled = 1'b0;
  logic [7:0]  tx_hold = 8'h00;

  function automatic logic [31:0] word_of(input int k);
    logic [31:0] w;
    for (int j = 0; j < 4; j++) w[8*j +: 8] = 8'(4 * k + j);
    return w;
  endfunction

  function automatic logic [7:0] hexc(input int n);
    if (n < 10) return 8'(8'h30 + n);
    else        return 8'(8'h61 + n - 10);
  endfunction

  // Monitors sample at the falling edge: valid&&ready here means a transfer on the next rise.
  initial forever begin
    @(negedge clk);
    if (rx_ack) n_ack++;
    if (rx_ack && sha3_in_valid) n_ack_in_push++;
    if (sha3_abort) n_abort++;
    if (in_stalled)
      check_eq("in_beat_stable", 64'({sha3_in_valid, sha3_in_data, sha3_in_keep, sha3_in_last}),
               64'(in_hold));
    in_stalled = sha3_in_valid && !sha3_in_ready;
    in_hold    = {1'b1, sha3_in_data, sha3_in_keep, sha3_in_last};
    if (sha3_in_valid && sha3_in_ready) begin
      q_dat.push_back(sha3_in_data);
      q_keep.push_back(sha3_in_keep);
      q_last.push_back(sha3_in_last);
      if (sha3_in_last) begin
        dig_pending = 1'b1;
        dig_idx     = 0;
      end
    end
    if (tx_stalled) check_eq("tx_stable", 64'({tx_valid, tx_data}), 64'({1'b1, tx_hold}));
    tx_stalled = tx_valid && !tx_ready;
    tx_hold    = tx_data;
    if (tx_valid && tx_ready) q_tx.push_back(tx_data);
    dig_xfer = sha3_out_valid && sha3_out_ready;
  end

  // Digest stub and TX ready driver, updated just after the rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    if (dig_xfer) dig_idx++;
    if (dig_idx >= 8) dig_pending = 1'b0;
    sha3_out_valid = dig_pending;
    sha3_out_data  = word_of(dig_idx);
    tx_ready       = tx_throttle ? ((cyc % 3) != 2) : 1'b1;
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    while (rx_ack !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("rx_ack_seen", 64'(n < 200), 64'd1);
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_idle"}, 64'(n < 3000), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_sb();
    q_dat.delete();
    q_keep.delete();
    q_last.delete();
    q_tx.delete();
    n_ack = 0;
    n_abort = 0;
    n_ack_in_push = 0;
  endtask

  task automatic check_beat(input string tag, input int i, input logic [31:0] d,
                            input logic [2:0] k, input logic l);
    if (i < q_dat.size()) begin
      check_eq({tag, "_data"}, 64'(q_dat[i]), 64'(d));
      check_eq({tag, "_keep"}, 64'(q_keep[i]), 64'(k));
      check_eq({tag, "_last"}, 64'(q_last[i]), 64'(l));
    end else begin
      check_eq({tag, "_present"}, 64'(q_dat.size()), 64'(i + 1));
    end
  endtask

  task automatic check_bin_digest(input string tag);
    check_eq({tag, "_txlen"}, 64'(q_tx.size()), 64'd32);
    for (int i = 0; i < 32 && i < q_tx.size(); i++)
      check_eq({tag, "_txbyte"}, 64'(q_tx[i]), 64'(i));
  endtask

  initial begin
    #200_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    check_eq("rst_ctrl_outs",
             64'({rx_ack, tx_valid, tx_data, sha3_in_valid, sha3_in_last, sha3_in_keep,
                  sha3_abort, sha3_out_ready, busy}), 64'd0);
    check_eq("rst_in_data", 64'(sha3_in_data), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Short binary message.
    clear_sb();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h61); send_byte(8'h62); send_byte(8'h63);
    wait_idle("t1");
    check_eq("t1_beats", 64'(q_dat.size()), 64'd1);
    check_beat("t1_b0", 0, 32'h0063_6261, 3'd3, 1'b1);
    check_eq("t1_acks", 64'(n_ack), 64'd6);
    check_bin_digest("t1");

    // Exact word multiple, hex output, with TX backpressure.
    clear_sb();
    tx_throttle = 1'b1;
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h08);
    for (int i = 0; i < 8; i++) send_byte(8'(i));
    wait_idle("t2");
    tx_throttle = 1'b0;
    check_eq("t2_beats", 64'(q_dat.size()), 64'd2);
    check_beat("t2_b0", 0, 32'h0302_0100, 3'd4, 1'b0);
    check_beat("t2_b1", 1, 32'h0706_0504, 3'd4, 1'b1);
    check_eq("t2_txlen", 64'(q_tx.size()), 64'd65);
    for (int i = 0; i < 32 && 2 * i + 1 < q_tx.size(); i++) begin
      check_eq("t2_hex_hi", 64'(q_tx[2*i]),   64'(hexc(i / 16)));
      check_eq("t2_hex_lo", 64'(q_tx[2*i+1]), 64'(hexc(i % 16)));
    end
    if (q_tx.size() == 65) check_eq("t2_newline", 64'(q_tx[64]), 64'h0A);

    // Zero-length message.
    clear_sb();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    wait_idle("t3");
    check_eq("t3_beats", 64'(q_dat.size()), 64'd1);
    check_beat("t3_b0", 0, 32'h0, 3'd0, 1'b1);
    check_bin_digest("t3");

    // Bad command.
    clear_sb();
    send_byte(8'h7E);
    wait_idle("t4");
    check_eq("t4_txlen", 64'(q_tx.size()), 64'd1);
    if (q_tx.size() > 0) check_eq("t4_nak", 64'(q_tx[0]), 64'h15);
    check_eq("t4_beats", 64'(q_dat.size()), 64'd0);
    check_eq("t4_busy", 64'(busy), 64'd0);
    check_eq("t4_acks", 64'(n_ack), 64'd1);

    // Inter-byte timeout after one beat was pushed.
    clear_sb();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h06);
    send_byte(8'h61); send_byte(8'h62); send_byte(8'h63); send_byte(8'h64);
    wait_idle("t5");
    check_eq("t5_beats", 64'(q_dat.size()), 64'd1);
    check_beat("t5_b0", 0, 32'h6463_6261, 3'd4, 1'b0);
    check_eq("t5_aborts", 64'(n_abort), 64'd1);
    check_eq("t5_txlen", 64'(q_tx.size()), 64'd1);
    if (q_tx.size() > 0) check_eq("t5_nak", 64'(q_tx[0]), 64'h15);

    // Hash-core backpressure during a 9-byte message.
    clear_sb();
    sha3_in_ready = 1'b0;
    fork
      begin
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h09);
        for (int i = 0; i < 9; i++) send_byte(8'(8'h10 + i));
      end
      begin
        int n = 0;
        while (!sha3_in_valid && n < 500) begin
          @(negedge clk);
          n++;
        end
        check_eq("t6_stall_seen", 64'(n < 500), 64'd1);
        repeat (50) @(posedge clk);
        #1 sha3_in_ready = 1'b1;
      end
    join
    wait_idle("t6");
    check_eq("t6_beats", 64'(q_dat.size()), 64'd3);
    check_beat("t6_b0", 0, 32'h1312_1110, 3'd4, 1'b0);
    check_beat("t6_b1", 1, 32'h1716_1514, 3'd4, 1'b0);
    check_beat("t6_b2", 2, 32'h0000_0018, 3'd1, 1'b1);
    check_eq("t6_ack_in_push", 64'(n_ack_in_push), 64'd0);
    check_eq("t6_acks", 64'(n_ack), 64'd12);
    check_bin_digest("t6");

    // Reset mid-frame, then a clean frame afterwards.
    clear_sb();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h05); send_byte(8'h61);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_eq("t7_rst_busy", 64'(busy), 64'd0);
    check_eq("t7_rst_outs",
             64'({tx_valid, sha3_in_valid, sha3_in_keep, sha3_in_last, sha3_abort, sha3_in_data}),
             64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("t7_no_abort", 64'(n_abort), 64'd0);
    clear_sb();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h01); send_byte(8'h41);
    wait_idle("t7");
    check_eq("t7_beats", 64'(q_dat.size()), 64'd1);
    check_beat("t7_b0", 0, 32'h0000_0041, 3'd1, 1'b1);
    check_bin_digest("t7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sha3_stream_bridge.md
# sha3_stream_bridge

Parametrised byte-stream to hash-core bridge between the UART RX/TX pair and the SHA3 wrapper in the hardware-accelerator top level. It parses length-prefixed command frames from the UART receiver and packs payload bytes into WORD_W-bit beats with a last-beat byte count. It then serialises the returned digest to the UART transmitter as raw binary or lowercase ASCII hex. It adds an inter-byte timeout with abort and NAK on malformed frames.

## Interface
- WORD_W, 32 — hash-core beat width in bits; 32 or 64
- LEN_BYTES, 2 — length-prefix size in bytes, big-endian; 1..4
- DIGEST_BITS, 256 — digest size; multiple of WORD_W
- TIMEOUT_CYC, 1_250_000 — idle cycles allowed between bytes inside a frame
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- rx_data  in  8  received byte
- rx_ready  in  1  byte available
- rx_ack  out  1  one-cycle consume pulse
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx byte valid
- tx_ready  in  1  transmitter accepts
- sha3_in_data  out  WORD_W  packed payload, first byte in bits [7:0]
- sha3_in_valid  out  1  beat valid
- sha3_in_last  out  1  final beat of message
- sha3_in_keep  out  $clog2(WORD_W/8)+1  valid bytes in final beat; 0..WORD_W/8
- sha3_in_ready  in  1  core accepts beat
- sha3_abort  out  1  one-cycle pulse; core discards partial message
- sha3_out_data  in  WORD_W  digest word, first-transmitted byte in [7:0]
- sha3_out_valid  in  1  digest word valid
- sha3_out_ready  out  1  bridge accepts digest word
- busy  out  1  high outside IDLE

## Operation
- **Frame format:** CMD byte, then LEN (LEN_BYTES, MSB first), then LEN payload bytes.
- **Commands:** CMD 0x01 selects binary output. CMD 0x02 selects hex output. Any other CMD causes a NAK byte 0x15 to be sent, then return to IDLE.
- **States:** IDLE, LEN, PAYLOAD, PUSH, WAIT_DIG, TX_BYTE, TX_HI, TX_LO, TX_NL, NAK.
- **IDLE:** on rx_ready, ack the byte and decode CMD. A valid CMD goes to LEN.
- **LEN:** collects LEN_BYTES bytes into the remaining-byte counter. If LEN==0, go to PUSH with keep=0 and last=1. Otherwise go to PAYLOAD.
- **PAYLOAD:** each acked byte is shifted into the packer and the counter decrements. When the word fills or the counter reaches 0, go to PUSH.
- **PUSH:** hold sha3_in_valid until sha3_in_ready. A full non-final beat has keep=WORD_W/8 and last=0. The final beat has last=1 and keep=remaining (WORD_W/8 if the length is an exact multiple). After the final beat go to WAIT_DIG; otherwise return to PAYLOAD.
- **Backpressure:** no rx_ack while in PUSH, so backpressure is held in the UART.
- **WAIT_DIG:** assert sha3_out_ready while the shift register is empty. Capture the word, then go to TX_BYTE (binary) or TX_HI (hex).
- **Per-byte serialisation:** emit bytes [7:0] first, WORD_W/8 bytes per word.
  - Binary: send the byte as-is.
  - Hex: TX_HI sends the ASCII of the high nibble, TX_LO the low nibble; '0'-'9', 'a'-'f'.
- **End of digest:** after DIGEST_BITS/WORD_W words, hex mode appends TX_NL (0x0A). Then return to IDLE.
- **Timeout:** in LEN or PAYLOAD, an idle counter reloads on each ack. On expiry:
  - pulse sha3_abort if at least one beat has been pushed;
  - clear the packer and go to NAK.
- **NAK:** send 0x15, then go to IDLE.
- **Width rules:** the byte counter is 8*LEN_BYTES bits and the word counter is $clog2(DIGEST_BITS/WORD_W)+1 bits; neither wraps.

## Timing
- **Reset values:** every output is 0 at reset; the state is IDLE.
- **rx_ack:**
  - a single-cycle pulse, asserted only when rx_ready=1 and the state is consuming;
  - at most one ack per 2 cycles, since the UART drops rx_ready the cycle after the ack.
- **Input beat latency:** sha3_in_valid asserts the cycle after the ack of the byte that completes the beat. A beat transfers on valid&&ready; data, keep and last stay stable while stalled.
- **Digest capture:** a transfer on sha3_out_valid&&sha3_out_ready. tx_valid asserts the next cycle.
- **tx handshake:** tx_data stays stable until tx_valid&&tx_ready. The next byte is presented in the following cycle, with no bubble beyond 1 cycle.
- **Simultaneous timeout expiry and rx_ready:** the byte wins and the counter reloads.
- **Reset mid-frame:** immediate return to IDLE with outputs 0. No abort pulse is generated.

## Structure
- **Package sha3_bridge_pkg:**
  - CMD_BIN=0x01, CMD_HEX=0x02, NAK=0x15, NL=0x0A;
  - state enum;
  - function nibble_to_ascii.
- **Sub-module sha3_byte_packer:** byte shift-in, fill count, keep, clear. It is parametrised by WORD_W.

## Test plan
All scenarios use a SHA3 stub that returns digest words 0x03020100, 0x07060504, ….
- **Short binary message:** WORD_W=32; send 01 00 03 61 62 63 -> one beat data=0x00636261, keep=3, last=1; then tx bytes 00 01 02 … 1F (32 bytes).
- **Exact word multiple, hex:** send 02 00 08 plus bytes 00..07 -> beats 0x03020100 (last=0) and 0x07060504 (keep=4, last=1); tx "000102…1f" plus 0x0A (65 bytes).
- **Zero length:** send 01 00 00 -> single beat keep=0, last=1; then 32 digest bytes.
- **Bad command:** send 0x7E -> tx 0x15 only, no sha3 activity, busy low afterwards.
- **Timeout:** TIMEOUT_CYC=100; send 01 00 06 61 62 63 64, then silence -> one beat pushed, sha3_abort pulses once, tx 0x15.
- **Backpressure:** hold sha3_in_ready low 50 cycles during a 9-byte message -> no rx_ack during the stall; beats stay stable; final keep=1.
